// File: rtl/core_pkg.sv
// Shared types and defaults for the core memory-port arbiter.
package core_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } arb_owner_t;

    localparam int ARB_STARVE_MAX_DEF = 4;

    // Saturating 4-bit increment used by the D-side starvation streak.
    function automatic logic [3:0] sat_inc(input logic [3:0] v, input logic [3:0] max);
        return (v >= max) ? max : v + 4'd1;
    endfunction

endpackage

// File: rtl/mem_arb_if.sv
// Fetch, load/store and memory-side signal bundle for mem_arbiter.
interface mem_arb_if #(
    parameter int AW = 32
);
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic          i_kill;
    logic          i_gnt;
    logic          i_rvalid;
    logic [31:0]   i_rdata;

    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [31:0]   d_wdata;
    logic [3:0]    d_be;
    logic          d_gnt;
    logic          d_rvalid;
    logic [31:0]   d_rdata;

    logic          m_req;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [31:0]   m_wdata;
    logic [3:0]    m_be;
    logic          m_gnt;
    logic          m_rvalid;
    logic [31:0]   m_rdata;

    // Arbiter view: takes core requests, drives the memory port.
    modport master (
        input  i_req, i_addr, i_kill,
        input  d_req, d_we, d_addr, d_wdata, d_be,
        input  m_gnt, m_rvalid, m_rdata,
        output i_gnt, i_rvalid, i_rdata,
        output d_gnt, d_rvalid, d_rdata,
        output m_req, m_we, m_addr, m_wdata, m_be
    );

    // Environment view: fetch/memory stages and the memory itself.
    modport slave (
        output i_req, i_addr, i_kill,
        output d_req, d_we, d_addr, d_wdata, d_be,
        output m_gnt, m_rvalid, m_rdata,
        input  i_gnt, i_rvalid, i_rdata,
        input  d_gnt, d_rvalid, d_rdata,
        input  m_req, m_we, m_addr, m_wdata, m_be
    );
endinterface

// File: rtl/mem_arb_perf.sv
// Grant and fetch-stall event counters for mem_arbiter (built only with MEM_ARB_PERF_EN).
module mem_arb_perf (
    input  logic        clock,
    input  logic        reset,
    input  logic        i_req,
    input  logic        i_gnt,
    input  logic        d_gnt,
    output logic [31:0] perf_i_grants,
    output logic [31:0] perf_d_grants,
    output logic [31:0] perf_i_stall
);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            perf_i_grants <= '0;
            perf_d_grants <= '0;
            perf_i_stall  <= '0;
        end else begin
            if (i_gnt)          perf_i_grants <= perf_i_grants + 32'd1;
            if (d_gnt)          perf_d_grants <= perf_d_grants + 32'd1;
            if (i_req && !i_gnt) perf_i_stall <= perf_i_stall + 32'd1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Single-outstanding arbiter sharing one memory port between fetch (I) and load/store (D).
// D has priority with a starvation guard; optional perf counters under MEM_ARB_PERF_EN.
module mem_arbiter
    import core_pkg::*;
#(
    parameter int STARVE_MAX = ARB_STARVE_MAX_DEF,
    parameter int AW         = 32
) (
    input  logic        clock,
    input  logic        reset,
    mem_arb_if.master   bus
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [31:0] perf_i_grants,
    output logic [31:0] perf_d_grants,
    output logic [31:0] perf_i_stall
`endif
);

    localparam logic [3:0] SMAX = 4'(STARVE_MAX);

    arb_state_t    state_q, state_d;
    arb_owner_t    owner_q, owner_d;
    logic          killed_q, killed_d;
    logic [3:0]    d_streak, d_streak_d;
    logic          latch;

    logic          m_req_q;
    logic          m_we_q;
    logic [AW-1:0] m_addr_q;
    logic [31:0]   m_wdata_q;
    logic [3:0]    m_be_q;

    logic          starve;
    assign starve = bus.i_req && (d_streak == SMAX);

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        latch      = 1'b0;
        killed_d   = killed_q;
        d_streak_d = d_streak;

        unique case (state_q)
            IDLE: begin
                if (bus.d_req && !starve) begin
                    owner_d = OWN_D;
                    latch   = 1'b1;
                    state_d = ISSUE;
                end else if (bus.i_req && !bus.i_kill) begin
                    owner_d = OWN_I;
                    latch   = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (bus.m_gnt)
                    state_d = WAIT;
                else if (owner_q == OWN_I && bus.i_kill)
                    state_d = IDLE;
            end
            WAIT: begin
                if (bus.m_rvalid)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // A kill only sticks to an I transaction memory has already accepted.
        if (state_d == IDLE)
            killed_d = 1'b0;
        else if (owner_q == OWN_I && bus.i_kill &&
                 (state_q == WAIT || (state_q == ISSUE && bus.m_gnt)))
            killed_d = 1'b1;

        if (state_q == IDLE) begin
            if (!bus.i_req)
                d_streak_d = 4'd0;
            else if (latch && owner_d == OWN_D)
                d_streak_d = sat_inc(d_streak, SMAX);
            else if (latch && owner_d == OWN_I)
                d_streak_d = 4'd0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            owner_q  <= OWN_D;
            killed_q <= 1'b0;
            d_streak <= 4'd0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            killed_q <= killed_d;
            d_streak <= d_streak_d;
        end
    end

    // Memory request fields are captured at arbitration and held through ISSUE.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            m_req_q   <= 1'b0;
            m_we_q    <= 1'b0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            m_be_q    <= '0;
        end else begin
            m_req_q <= (state_d == ISSUE);
            if (latch) begin
                if (owner_d == OWN_D) begin
                    m_we_q    <= bus.d_we;
                    m_addr_q  <= bus.d_addr;
                    m_wdata_q <= bus.d_wdata;
                    m_be_q    <= bus.d_be;
                end else begin
                    m_we_q    <= 1'b0;
                    m_addr_q  <= bus.i_addr;
                    m_wdata_q <= '0;
                    m_be_q    <= 4'hF;
                end
            end
        end
    end

    assign bus.m_req   = m_req_q;
    assign bus.m_we    = m_we_q;
    assign bus.m_addr  = m_addr_q;
    assign bus.m_wdata = m_wdata_q;
    assign bus.m_be    = m_be_q;

    logic issue_acc, wait_resp;
    assign issue_acc = (state_q == ISSUE) && bus.m_gnt;
    assign wait_resp = (state_q == WAIT) && bus.m_rvalid;

    assign bus.i_gnt    = issue_acc && (owner_q == OWN_I);
    assign bus.d_gnt    = issue_acc && (owner_q == OWN_D);
    assign bus.i_rvalid = wait_resp && (owner_q == OWN_I) && !killed_q;
    assign bus.d_rvalid = wait_resp && (owner_q == OWN_D);
    assign bus.i_rdata  = bus.m_rdata;
    assign bus.d_rdata  = bus.m_rdata;

`ifdef MEM_ARB_PERF_EN
    mem_arb_perf u_perf (
        .clock         (clock),
        .reset         (reset),
        .i_req         (bus.i_req),
        .i_gnt         (bus.i_gnt),
        .d_gnt         (bus.d_gnt),
        .perf_i_grants (perf_i_grants),
        .perf_d_grants (perf_d_grants),
        .perf_i_stall  (perf_i_stall)
    );
`endif

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the core's single memory port between instruction fetch (I-side, driven by the fetch stage) and load/store (D-side, driven by the memory stage). One transaction is in flight at a time. D-side has priority, with a starvation guard that guarantees fetch progress. An I-side kill input drops stale fetches after a branch redirect.

## Interface
Parameters:
- STARVE_MAX, 4: consecutive D grants allowed while i_req is pending before I is forced; legal range 1..15.
- AW, 32: address width.

Ports:
- clock  in  1  core clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high.
- i_req  in  1  fetch request; held with i_addr stable until i_gnt.
- i_addr  in  AW  fetch address, word aligned.
- i_kill  in  1  branch redirect; discards any I transaction not yet returned.
- i_gnt  out  1  one-cycle pulse when memory accepts the I request.
- i_rvalid  out  1  I read data valid, one cycle.
- i_rdata  out  32  I read data.
- d_req  in  1  data request; held with all d_* fields stable until d_gnt.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  AW  data address.
- d_wdata  in  32  store data.
- d_be  in  4  store byte enables.
- d_gnt  out  1  one-cycle pulse when memory accepts the D request.
- d_rvalid  out  1  load data valid, or store acknowledge, one cycle.
- d_rdata  out  32  load data.
- m_req, m_we, m_addr, m_wdata, m_be  out  1/1/AW/32/4  memory request fields, registered.
- m_gnt  in  1  memory accepts the request presented this cycle.
- m_rvalid  in  1  memory response; exactly one per accepted request, for both reads and writes.
- m_rdata  in  32  memory read data.

## Operation
- FSM states: IDLE, ISSUE, WAIT.
- IDLE
  - If d_req and not (i_req and d_streak == STARVE_MAX): owner = D.
  - Otherwise, if i_req and not i_kill: owner = I.
  - On a grant, latch the owner's fields into the m_* registers and go to ISSUE.
  - With no request, stay in IDLE.
- ISSUE: m_req = 1.
  - On m_gnt: pulse the owner's gnt (combinational: m_gnt & owner) and go to WAIT.
  - If owner = I and i_kill is high without m_gnt: drop m_req and return to IDLE. No i_gnt is produced.
- WAIT: m_req = 0. On m_rvalid, return to IDLE.
- Response routing:
  - d_rvalid = m_rvalid & owner == D.
  - i_rvalid = m_rvalid & owner == I & !killed.
  - i_rdata and d_rdata are wired directly from m_rdata.
- killed flag:
  - Set when i_kill is seen in WAIT, or in the ISSUE cycle in which m_gnt is accepted, with owner = I.
  - Cleared on entry to IDLE.
- d_streak (4-bit):
  - Increments on a D grant while i_req is high, saturating at STARVE_MAX.
  - Clears on an I grant, or when i_req is low at arbitration.
- Reset values: state IDLE, owner D, every m_* output 0, d_streak 0, killed 0, all gnt/rvalid outputs 0.

## Timing
- Request visible in IDLE at cycle N: m_req high at N+1. With m_gnt at N+1, gnt pulses at N+1. With m_rvalid at N+2, rvalid/rdata arrive at N+2 and the FSM is back in IDLE at N+3.
- Peak throughput: one transaction per 3 cycles. m_gnt stalls lengthen ISSUE; memory latency lengthens WAIT.
- i_req and d_req in the same IDLE cycle: D wins unless the starvation limit has been reached.
- i_kill in the same IDLE cycle as i_req: no I grant.
- i_kill is ignored when owner = D.
- m_rvalid is ignored outside WAIT.
- Asynchronous reset mid-transaction abandons it immediately. The memory shares the same reset.

## Configuration
- MEM_ARB_PERF_EN defined adds three 32-bit wrapping counters and output ports perf_i_grants, perf_d_grants, perf_i_stall:
  - perf_i_grants increments per i_gnt.
  - perf_d_grants increments per d_gnt.
  - perf_i_stall increments on each cycle with i_req & !i_gnt.
  - All three reset to 0.
- Undefined: the counters and ports are absent and there is no functional difference.

## Structure
- core_pkg holds:
  - arb_state_t enum (IDLE, ISSUE, WAIT).
  - arb_owner_t enum (OWN_I, OWN_D).
  - localparam ARB_STARVE_MAX_DEF = 4.
- Sub-module mem_arb_perf contains the three perf counters. It is instantiated only under MEM_ARB_PERF_EN.

## Test plan
- Lone fetch:
  - Stimulus: i_req with i_addr=0x40; m_gnt immediate; m_rvalid next cycle with m_rdata=0x00500093.
  - Required: i_gnt at N+1; i_rvalid with i_rdata=0x00500093 at N+2; d_gnt never asserted.
- Simultaneous requests:
  - Stimulus: i_req and d_req (load, addr 0x100) in the same cycle.
  - Required: D served first, I granted in the next IDLE; d_streak returns to 0 after the I grant.
- Starvation guard:
  - Stimulus: d_req held continuously for 10 transactions; i_req held; STARVE_MAX=4.
  - Required: grant order D,D,D,D,I,D,D,D,D,I.
- Kill in flight:
  - Stimulus: I granted; i_kill in WAIT; m_rvalid two cycles later.
  - Required: no i_rvalid; next arbitration proceeds normally.
- Kill before accept and mid-transaction reset:
  - Stimulus: owner I in ISSUE with m_gnt held low; i_kill asserted.
  - Required: m_req drops next cycle and no i_gnt.
  - Stimulus: reset asserted in WAIT.
  - Required: all outputs 0 immediately; state IDLE.
- Store acknowledge:
  - Stimulus: d_we=1, d_be=4'b0011, d_wdata=0xDEADBEEF.
  - Required: m_be=0011, m_wdata=0xDEADBEEF presented with m_req; d_rvalid on m_rvalid.
